// File: rtl/lcd_hd44780_nibble_if.sv
// HD44780 4-bit mode front end: power-on init, then RS+byte requests split
// into high/low nibbles with E pulse and execution-wait timing.
module lcd_hd44780_nibble_if #(
    parameter int E_HIGH_CYCLES       = 24,
    parameter int CMD_WAIT_CYCLES     = 2000,
    parameter int CLEAR_WAIT_CYCLES   = 82000,
    parameter int INIT_WAIT_CYCLES    = 205000,
    parameter int POWERUP_WAIT_CYCLES = 750000,
    parameter int CNT_W               = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_d
);

    typedef enum logic [2:0] {
        PWRUP, INIT, IDLE, SETUP, EHIGH, ELOW, WAIT
    } state_t;

    // Counter load values are N-1 so a parameter N yields exactly N cycles.
    localparam logic [CNT_W-1:0] C_EH   = CNT_W'(E_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CMD  = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CLR  = CNT_W'(CLEAR_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_INIT = CNT_W'(INIT_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_PWR  = CNT_W'(POWERUP_WAIT_CYCLES - 1);
    localparam logic [3:0]       LAST_INIT = 4'd8;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_idx;
    logic [3:0]       r_lo_nib;
    logic             r_lo_pend;
    logic [CNT_W-1:0] r_wait;
    logic             r_ready;
    logic             r_done;
    logic             r_rs;
    logic             r_e;
    logic [3:0]       r_d;

    logic [7:0]       w_init_d;
    logic [CNT_W-1:0] w_init_wait;
    logic             w_init_byte;

    function automatic logic [CNT_W-1:0] f_wait(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
            return C_CLR;
        return C_CMD;
    endfunction

    // Items 0..3 are lone nibbles (in bits 7:4), items 4..8 are full bytes.
    always_comb begin
        w_init_d    = 8'h00;
        w_init_wait = C_CMD;
        w_init_byte = (r_idx >= 4'd4);
        case (r_idx)
            4'd0:    begin w_init_d = 8'h30; w_init_wait = C_INIT; end
            4'd1:    begin w_init_d = 8'h30; w_init_wait = C_INIT; end
            4'd2:    w_init_d = 8'h30;
            4'd3:    w_init_d = 8'h20;
            4'd4:    w_init_d = 8'h28;
            4'd5:    w_init_d = 8'h08;
            4'd6:    w_init_d = 8'h01;
            4'd7:    w_init_d = 8'h06;
            4'd8:    w_init_d = 8'h0C;
            default: w_init_d = 8'h00;
        endcase
        if (w_init_byte)
            w_init_wait = f_wait(1'b0, w_init_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= PWRUP;
            r_cnt     <= C_PWR;
            r_idx     <= 4'd0;
            r_lo_nib  <= 4'h0;
            r_lo_pend <= 1'b0;
            r_wait    <= '0;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_rs      <= 1'b0;
            r_e       <= 1'b0;
            r_d       <= 4'h0;
        end else begin
            case (r_state)
                PWRUP: begin
                    if (r_cnt == '0) r_state <= INIT;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                INIT: begin
                    r_rs      <= 1'b0;
                    r_d       <= w_init_d[7:4];
                    r_lo_nib  <= w_init_d[3:0];
                    r_lo_pend <= w_init_byte;
                    r_wait    <= w_init_wait;
                    r_state   <= SETUP;
                end
                IDLE: begin
                    if (in_valid && r_ready) begin
                        r_ready   <= 1'b0;
                        r_rs      <= in_rs;
                        r_d       <= in_data[7:4];
                        r_lo_nib  <= in_data[3:0];
                        r_lo_pend <= 1'b1;
                        r_wait    <= f_wait(in_rs, in_data);
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_e     <= 1'b1;
                    r_cnt   <= C_EH;
                    r_state <= EHIGH;
                end
                EHIGH: begin
                    if (r_cnt == '0) begin
                        r_e     <= 1'b0;
                        r_cnt   <= C_EH;
                        r_state <= ELOW;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ELOW: begin
                    if (r_cnt == '0) begin
                        if (r_lo_pend) begin
                            r_lo_pend <= 1'b0;
                            r_d       <= r_lo_nib;
                            r_state   <= SETUP;
                        end else begin
                            r_cnt   <= r_wait;
                            r_state <= WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_done) begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_idx == LAST_INIT) begin
                        // init_done and the first in_ready rise together
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= INIT;
                    end
                end
                default: r_state <= PWRUP;
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign init_done = r_done;
    assign lcd_rs    = r_rs;
    assign lcd_e     = r_e;
    assign lcd_d     = r_d;

endmodule

// File: tb/tb_lcd_hd44780_nibble_if.sv
// Directed bench for lcd_hd44780_nibble_if with shortened timing parameters.
module tb_lcd_hd44780_nibble_if;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_e;
    logic [3:0] lcd_d;

    lcd_hd44780_nibble_if #(
        .E_HIGH_CYCLES(2), .CMD_WAIT_CYCLES(10), .CLEAR_WAIT_CYCLES(40),
        .INIT_WAIT_CYCLES(20), .POWERUP_WAIT_CYCLES(100), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_data(in_data), .init_done(init_done),
        .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_d(lcd_d)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    int viol = 0;
    int unstable = 0;
    int width = 0;
    logic       prev_e = 1'b0;
    logic [4:0] cap = 5'h0;
    logic [4:0] pq[$];
    logic [4:0] eq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: records {rs,d} per E pulse, checks width and data hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_e = 1'b0;
            width  = 0;
        end else begin
            if (lcd_e && !prev_e) begin
                pq.push_back({lcd_rs, lcd_d});
                cap   = {lcd_rs, lcd_d};
                width = 1;
            end else if (lcd_e) begin
                width++;
                if ({lcd_rs, lcd_d} != cap) unstable++;
            end else if (prev_e) begin
                chk("e_width", width, 2);
            end
            if (in_ready && !init_done) viol++;
            prev_e = lcd_e;
        end
    end

    task automatic cmp_pulses(input string tag);
        chk({tag, "_cnt"}, pq.size(), eq.size());
        for (int i = 0; i < eq.size(); i++)
            if (i < pq.size()) chk($sformatf("%s_p%0d", tag, i), {27'h0, pq[i]}, {27'h0, eq[i]});
        pq.delete();
        eq.delete();
    endtask

    task automatic do_init(input string tag);
        int k;
        pq.delete();
        viol = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        k = 0;
        while (!lcd_e && k < 200) begin @(negedge clk); k++; end
        chk({tag, "_pwrup_quiet"}, (k >= 101 && k <= 104), 1);
        k = 0;
        while (!init_done && k < 3000) begin @(negedge clk); k++; end
        chk({tag, "_init_done"}, init_done, 1);
        chk({tag, "_rdy_with_done"}, in_ready, 1);
        chk({tag, "_rdy_in_init"}, viol, 0);
        eq = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00,
               5'h08, 5'h00, 5'h01, 5'h00, 5'h06, 5'h00, 5'h0C};
        cmp_pulses({tag, "_init"});
    endtask

    // Returns the number of cycles waited for in_ready before acceptance.
    task automatic send(input logic rs, input logic [7:0] d, input int exp_dt, output int wt);
        int k;
        in_rs = rs; in_data = d; in_valid = 1'b1;
        wt = 0;
        while (!in_ready && wt < 500) begin @(posedge clk); #1; wt++; end
        chk($sformatf("acc_rdy_%02h", d), in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = 8'hFF; in_rs = ~rs;
        chk($sformatf("rdy_drop_%02h", d), in_ready, 0);
        k = 0;
        while (!in_ready && k < 500) begin @(posedge clk); #1; k++; end
        chk($sformatf("dt_%02h", d), k, exp_dt);
    endtask

    initial begin
        int wt, kk;
        rst_n = 1'b0; in_valid = 1'b0; in_rs = 1'b0; in_data = 8'h00;
        #1;
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_d", lcd_d, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_done", init_done, 0);
        repeat (3) @(negedge clk);

        // request held through init; must be taken on the first ready cycle
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h48;
        do_init("a");
        send(1'b1, 8'h48, 20, wt);
        chk("first_rdy_acc", wt, 0);
        eq = '{5'h14, 5'h18}; cmp_pulses("H");

        send(1'b0, 8'h01, 50, wt);
        eq = '{5'h00, 5'h01}; cmp_pulses("clr");
        send(1'b1, 8'h01, 20, wt);
        eq = '{5'h10, 5'h11}; cmp_pulses("d01");

        // back-to-back: in_valid never drops across three bytes
        in_rs = 1'b1; in_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            in_data = 8'h41 + 8'(b);
            kk = 0;
            while (!in_ready && kk < 500) begin @(posedge clk); #1; kk++; end
            if (b > 0) chk($sformatf("b2b_gap%0d", b), kk, 20);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        kk = 0;
        while (!in_ready && kk < 500) begin @(posedge clk); #1; kk++; end
        chk("b2b_last_dt", kk, 20);
        eq = '{5'h14, 5'h11, 5'h14, 5'h12, 5'h14, 5'h13}; cmp_pulses("b2b");

        // reset in the middle of an E-high phase
        in_rs = 1'b1; in_data = 8'h55; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        kk = 0;
        while (!lcd_e && kk < 50) begin @(negedge clk); kk++; end
        chk("pre_rst_e", lcd_e, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_e", lcd_e, 0);
        chk("arst_rs", lcd_rs, 0);
        chk("arst_d", lcd_d, 0);
        chk("arst_rdy", in_ready, 0);
        chk("arst_done", init_done, 0);
        repeat (3) @(negedge clk);
        do_init("b");
        send(1'b0, 8'h02, 50, wt);
        eq = '{5'h00, 5'h02}; cmp_pulses("home");

        chk("d_stable", unstable, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_nibble_if.md
Name: lcd_hd44780_nibble_if

Overview:
- Byte-level front end for an HD44780-compatible character LCD in 4-bit mode.
- Consumes RS+byte requests from a message/character sequencer over a valid/ready handshake.
- Runs the power-on init sequence, then splits each byte into high/low nibbles with correct E-pulse and execution timing.
- Sits between upstream text logic and the LCD pins on uo_out.

Parameters:
- E_HIGH_CYCLES, 24: cycles E is held high per nibble; also the E-low cycles after each pulse.
- CMD_WAIT_CYCLES, 2000: execution wait after a normal byte.
- CLEAR_WAIT_CYCLES, 82000: execution wait after clear/home commands (RS=0, data 0x01/0x02/0x03).
- INIT_WAIT_CYCLES, 205000: wait after each of the first two init 0x3 nibbles.
- POWERUP_WAIT_CYCLES, 750000: idle time after reset release before the first init nibble.
- CNT_W, 20: delay counter width. Every cycle parameter must be < 2^CNT_W.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream request valid
- in_ready  output  1  block can accept a request
- in_rs  input  1  register select of the request (0=command, 1=data)
- in_data  input  8  byte to send
- init_done  output  1  init sequence complete; sticky until reset
- lcd_rs  output  1  LCD RS pin
- lcd_e  output  1  LCD E pin
- lcd_d  output  4  LCD D7..D4 (bit3=D7)

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0, all of these are 0 immediately: lcd_e, lcd_rs, lcd_d, in_ready, init_done.
- Reset asserted mid-operation aborts any transfer and restarts the full sequence, including the power-up wait.
- States: PWRUP, INIT, IDLE, SETUP, EHIGH, ELOW, WAIT.
- PWRUP: counts POWERUP_WAIT_CYCLES with all outputs at 0, then enters INIT.
- INIT issues these transfers in order, all with RS=0:
  - nibble 0x3, then INIT_WAIT_CYCLES
  - nibble 0x3, then INIT_WAIT_CYCLES
  - nibble 0x3, then CMD_WAIT_CYCLES
  - nibble 0x2, then CMD_WAIT_CYCLES
  - bytes 0x28, 0x08, 0x01 (CLEAR_WAIT_CYCLES), 0x06, 0x0C, each with CMD_WAIT_CYCLES except 0x01
  - Total: 14 E pulses.
- Nibble timing (shared by init and normal traffic), E_HIGH_CYCLES = EH:
  - SETUP: 1 cycle; lcd_rs/lcd_d driven, E=0.
  - EHIGH: EH cycles, E=1.
  - ELOW: EH cycles, E=0.
  - lcd_rs/lcd_d stay stable across SETUP, EHIGH and ELOW of a nibble.
  - Cost per nibble: 1+2·EH cycles.
- Byte transfer: high nibble first, then low nibble, then WAIT.
  - WAIT = CLEAR_WAIT_CYCLES if rs=0 and data ∈ {0x01,0x02,0x03}; otherwise CMD_WAIT_CYCLES.
- Handshake:
  - in_ready=1 only in IDLE with init_done=1.
  - Transfer occurs on a rising edge with in_valid & in_ready; in_rs/in_data are captured at that edge.
  - in_ready is 0 from the next cycle.
  - in_ready reasserts exactly 2·(1+2·EH)+WAIT cycles after the accepting edge.
  - A new request may be accepted on that same edge, giving back-to-back transfers with no extra gap.
  - in_valid while in_ready=0 is ignored; upstream must hold it.
  - in_rs/in_data may change after acceptance without effect.
- init_done and the first in_ready rise on the same cycle, at the end of the 0x0C wait.
- In IDLE/WAIT/PWRUP: lcd_e=0; lcd_rs/lcd_d hold the last driven values (0 after reset).
- lcd_e is a registered output, glitch-free, never high for other than exactly EH consecutive cycles.
- Delay counter saturates nowhere. It loads N−1 and counts to 0, so a parameter N gives exactly N cycles; N≥1 is required.

Test Plan:
Overrides for all scenarios: EH=2, CMD=10, CLEAR=40, INIT=20, PWRUP=100, CNT_W=8.
- Reset release → lcd_e stays 0 for 100 cycles, then 14 E pulses with nibbles 3,3,3,2,2,8,0,8,0,1,0,6,0,C (RS=0 throughout), then init_done=1 and in_ready=1 together; each pulse is exactly 2 cycles high.
- After init, send rs=1, data=0x48 ('H') → pulses show lcd_d=0x4 then 0x8 with lcd_rs=1; in_ready returns exactly 20 cycles after acceptance.
- Send rs=0, data=0x01 → nibbles 0x0, 0x1 with RS=0; in_ready returns after 50 cycles. Then rs=1, data=0x01 → 20 cycles (data byte, not clear).
- in_valid held high with 3 queued bytes 0x41, 0x42, 0x43 → accepted at 20-cycle spacing, no idle gap; 6 E pulses in order 4,1,4,2,4,3.
- Pulse rst_n low mid-EHIGH of a data byte → lcd_e/lcd_d/lcd_rs/in_ready/init_done go 0 asynchronously; after release, 100-cycle power-up wait and the full init sequence repeat.
- in_valid asserted during init → in_ready stays 0, no transfer until init_done; the request is then accepted on the first in_ready cycle.
